// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and default adder geometry.
package alu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_BLOCK = 8;
  localparam int DEFAULT_TAG_W = 5;

  function automatic int num_stages(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational BLOCK-bit carry-lookahead slice built from a two-level
// generate/propagate tree (bit groups, then the whole slice).
module cla_slice
  import alu_pkg::*;
#(
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb,
  output logic             G,
  output logic             P
);

  // First-level group size; falls back to smaller groups for odd slice widths.
  localparam int SG = (BLOCK % 4 == 0) ? 4 : ((BLOCK % 2 == 0) ? 2 : 1);
  localparam int NG = BLOCK / SG;

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      cg;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    cg = '0;
    c  = '0;
    G  = 1'b0;
    P  = 1'b1;

    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < SG; i++) begin
        gg[j] = g[j*SG+i] | (p[j*SG+i] & gg[j]);
        gp[j] = gp[j] & p[j*SG+i];
      end
    end

    // Second level: group carries and the slice-wide G/P.
    cg[0] = cin;
    for (int j = 0; j < NG; j++) begin
      cg[j+1] = gg[j] | (gp[j] & cg[j]);
      G       = gg[j] | (gp[j] & G);
      P       = P & gp[j];
    end

    for (int j = 0; j < NG; j++) begin
      c[j*SG] = cg[j];
      for (int i = 0; i < SG - 1; i++) begin
        c[j*SG+i+1] = g[j*SG+i] | (p[j*SG+i] & c[j*SG+i]);
      end
    end
    c[BLOCK] = cg[NG];

    sum   = p ^ c[BLOCK-1:0];
    cout  = c[BLOCK];
    c_msb = c[BLOCK-1];
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit slice resolved per
// stage, carry registered between stages, global-stall valid/ready flow control.
module pipelined_cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK,
  parameter int TAG_W = DEFAULT_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NS = num_stages(WIDTH, BLOCK);

  if ((BLOCK < 1) || (WIDTH % BLOCK != 0)) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK");
  end

  alu_op_e op_mode;
  logic    adv;

  logic [NS-1:0]            valid_q, valid_d;
  logic [NS-1:0][WIDTH-1:0] opa_q, opa_d;
  logic [NS-1:0][WIDTH-1:0] opb_q, opb_d;
  logic [NS-1:0][WIDTH-1:0] res_q, res_d;
  logic [NS-1:0]            carry_q, carry_d;
  logic [NS-1:0][TAG_W-1:0] tag_q, tag_d;
  logic                     cout_q, cout_d;
  logic                     ovf_q, ovf_d;
  logic                     zero_q, zero_d;

  logic [NS-1:0]            st_v;
  logic [NS-1:0][WIDTH-1:0] st_a;
  logic [NS-1:0][WIDTH-1:0] st_b;
  logic [NS-1:0][WIDTH-1:0] st_res;
  logic [NS-1:0]            st_c;
  logic [NS-1:0][TAG_W-1:0] st_tag;

  logic [NS-1:0][BLOCK-1:0] sl_sum;
  logic [NS-1:0]            sl_cout;
  logic [NS-1:0]            sl_cmsb;
  logic [NS-1:0]            sl_g;
  logic [NS-1:0]            sl_p;
  logic                     unused_sink;

  assign op_mode  = alu_op_e'(op_sub);
  assign adv      = !valid_q[NS-1] | out_ready;
  assign in_ready = adv;

  // Stage k works on what stage k-1 registered; stage 0 works on the ports,
  // with subtraction folded in as A + ~B + 1.
  always_comb begin
    st_v   = '0;
    st_a   = '0;
    st_b   = '0;
    st_res = '0;
    st_c   = '0;
    st_tag = '0;

    st_v[0]   = in_valid;
    st_a[0]   = data_a;
    st_b[0]   = (op_mode == OP_SUB) ? ~data_b : data_b;
    st_c[0]   = (op_mode == OP_SUB) ? 1'b1 : cin;
    st_tag[0] = in_tag;

    for (int k = 1; k < NS; k++) begin
      st_v[k]   = valid_q[k-1];
      st_a[k]   = opa_q[k-1];
      st_b[k]   = opb_q[k-1];
      st_res[k] = res_q[k-1];
      st_c[k]   = carry_q[k-1];
      st_tag[k] = tag_q[k-1];
    end
  end

  for (genvar k = 0; k < NS; k++) begin : g_stage
    cla_slice #(.BLOCK(BLOCK)) u_slice (
      .a     (st_a[k][k*BLOCK +: BLOCK]),
      .b     (st_b[k][k*BLOCK +: BLOCK]),
      .cin   (st_c[k]),
      .sum   (sl_sum[k]),
      .cout  (sl_cout[k]),
      .c_msb (sl_cmsb[k]),
      .G     (sl_g[k]),
      .P     (sl_p[k])
    );
  end

  always_comb begin
    valid_d = st_v;
    opa_d   = st_a;
    opb_d   = st_b;
    tag_d   = st_tag;
    carry_d = sl_cout;
    res_d   = st_res;
    for (int k = 0; k < NS; k++) begin
      res_d[k][k*BLOCK +: BLOCK] = sl_sum[k];
    end
    cout_d = sl_cout[NS-1];
    ovf_d  = sl_cmsb[NS-1] ^ sl_cout[NS-1];
    zero_d = (res_d[NS-1] == '0);
  end

  // Every stage register holds while the output is stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= '0;
      tag_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      valid_q <= valid_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      tag_q   <= tag_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q[NS-1];
  assign result    = res_q[NS-1];
  assign out_tag   = tag_q[NS-1];
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Slice-wide G/P and the last stage's leftover operands have no consumer.
  assign unused_sink = ^{sl_g, sl_p, sl_cmsb, opa_q[NS-1], opb_q[NS-1], carry_q[NS-1]};

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder (WIDTH=32, BLOCK=8): latency, flags,
// streaming, backpressure, mid-stream reset and a short randomised run.
module tb_pipelined_cla_adder;

  localparam int WIDTH = 32;
  localparam int BLOCK = 8;
  localparam int TAG_W = 5;
  localparam int NS    = WIDTH / BLOCK;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             o;
    logic             z;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] out_tag;

  int   total = 0;
  int   bad   = 0;
  exp_t expQ[$];

  pipelined_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK), .TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .data_a    (data_a),
    .data_b    (data_b),
    .cin       (cin),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .out_tag   (out_tag)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic c, input logic o,
                              input logic z, input logic [TAG_W-1:0] t);
    exp_t e;
    e.res = r; e.c = c; e.o = o; e.z = z; e.tag = t;
    return e;
  endfunction

  function automatic exp_t model(input logic sub, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic ci,
                                 input logic [TAG_W-1:0] t);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] bb;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub ? 1'b1 : ci)};
    return mk(s[WIDTH-1:0], s[WIDTH], (a[WIDTH-1] == bb[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]),
              (s[WIDTH-1:0] == '0), t);
  endfunction

  function automatic exp_t observed();
    return {result, cout, ovf, zero, out_tag};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic sub, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic ci,
                               input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    op_sub   = sub;
    data_a   = a;
    data_b   = b;
    cin      = ci;
    in_tag   = t;
  endtask

  task automatic runSingle(input string name, input logic sub, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic ci,
                           input logic [TAG_W-1:0] t, input exp_t e);
    int lat;
    out_ready = 1'b1;
    applyStimulus(sub, a, b, ci, t);
    @(negedge clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checkOutput({name, ".latency"}, 64'(lat), 64'(NS));
    checkOutput({name, ".out"}, 64'(observed()), 64'(e));
    @(negedge clock);
    checkOutput({name, ".drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic runTraffic(input string name, input int nOps, input bit rnd);
    int sent, got, extra, firstC, lastC, cyc;
    logic             sub, ci;
    logic [WIDTH-1:0] a, b;
    sent = 0; got = 0; extra = 0; firstC = -1; lastC = -1; cyc = 0;
    expQ.delete();
    while ((sent < nOps || expQ.size() > 0) && cyc < nOps * 8 + 40) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        if (expQ.size() > 0) begin
          checkOutput({name, ".out"}, 64'(observed()), 64'(expQ.pop_front()));
          got++;
        end else begin
          extra++;
        end
        if (firstC < 0) firstC = cyc;
        lastC = cyc;
      end
      if (in_ready) begin
        if (sent < nOps && (!rnd || $urandom_range(0, 3) != 0)) begin
          if (rnd) begin
            sub = 1'($urandom_range(0, 1));
            ci  = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
          end else begin
            sub = 1'b0;
            ci  = 1'(sent % 2);
            a   = 32'h1111_1111 * 32'(sent);
            b   = 32'h0F0F_0F0F;
          end
          applyStimulus(sub, a, b, ci, TAG_W'(sent));
          expQ.push_back(model(sub, a, b, ci, TAG_W'(sent)));
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clock);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput({name, ".received"}, 64'(got), 64'(nOps));
    checkOutput({name, ".extra"}, 64'(extra), 64'd0);
    if (!rnd) checkOutput({name, ".span"}, 64'(lastC - firstC), 64'(nOps - 1));
  endtask

  initial begin
    int   sent, got, extra, stale, guard;
    exp_t frozen;

    reset = 1'b1; in_valid = 1'b0; op_sub = 1'b0; data_a = '0; data_b = '0;
    cin = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("reset.outValid", 64'(out_valid), 64'd0);
    checkOutput("reset.outputs", 64'(observed()), 64'd0);
    checkOutput("reset.inReady", 64'(in_ready), 64'd1);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] directed vectors");
    runSingle("add.ff1",    1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 5'd1, mk(32'h0000_0100, 0, 0, 0, 5'd1));
    runSingle("add.wrap",   1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'd2, mk(32'h0000_0000, 1, 0, 1, 5'd2));
    runSingle("add.ovf",    1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5'd3, mk(32'h8000_0000, 0, 1, 0, 5'd3));
    runSingle("add.cin",    1'b0, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 5'd4, mk(32'h0001_0000, 0, 0, 0, 5'd4));
    runSingle("add.negovf", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 5'd5, mk(32'h0000_0000, 1, 1, 1, 5'd5));
    runSingle("sub.5m7",    1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 5'd6, mk(32'hFFFF_FFFE, 0, 0, 0, 5'd6));
    runSingle("sub.ovf",    1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 5'd7, mk(32'h7FFF_FFFF, 1, 1, 0, 5'd7));
    runSingle("sub.equal",  1'b1, 32'h0000_1234, 32'h0000_1234, 1'b0, 5'd8, mk(32'h0000_0000, 1, 0, 1, 5'd8));
    runSingle("sub.cinIgn", 1'b1, 32'h0000_000A, 32'h0000_0003, 1'b1, 5'd9, mk(32'h0000_0007, 1, 0, 0, 5'd9));

    $display("[TB] back-to-back stream");
    runTraffic("stream", 8, 1'b0);

    $display("[TB] backpressure");
    expQ.delete();
    out_ready = 1'b0;
    sent = 0; guard = 0;
    while (in_ready && guard < 20) begin
      applyStimulus(1'b0, 32'h1000_0000 * 32'(sent) + 32'h0000_00F0, 32'h0000_0010 + 32'(sent),
                    1'b0, TAG_W'(20 + sent));
      expQ.push_back(model(1'b0, 32'h1000_0000 * 32'(sent) + 32'h0000_00F0,
                           32'h0000_0010 + 32'(sent), 1'b0, TAG_W'(20 + sent)));
      sent++;
      guard++;
      @(negedge clock);
    end
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 5'd31);
    checkOutput("bp.accepted", 64'(sent), 64'(NS));
    frozen = observed();
    checkOutput("bp.head", 64'(frozen), 64'(expQ[0]));
    repeat (4) begin
      @(negedge clock);
      checkOutput("bp.inReady", 64'(in_ready), 64'd0);
      checkOutput("bp.frozen", 64'({out_valid, observed()}), 64'({1'b1, frozen}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got = 0; extra = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid) begin
        if (expQ.size() > 0) begin
          checkOutput("bp.drain", 64'(observed()), 64'(expQ.pop_front()));
          got++;
        end else begin
          extra++;
        end
      end
      @(negedge clock);
    end
    checkOutput("bp.drained", 64'(got), 64'(NS));
    checkOutput("bp.extra", 64'(extra), 64'd0);

    $display("[TB] reset with operations in flight");
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, WIDTH'(i + 1), 32'd100, 1'b0, TAG_W'(10 + i));
      @(negedge clock);
    end
    in_valid = 1'b0;
    checkOutput("rstMid.preValid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstMid.outValid", 64'(out_valid), 64'd0);
    checkOutput("rstMid.outputs", 64'(observed()), 64'd0);
    checkOutput("rstMid.inReady", 64'(in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    stale = 0;
    repeat (8) begin
      @(negedge clock);
      if (out_valid) stale++;
    end
    checkOutput("rstMid.stale", 64'(stale), 64'd0);
    runSingle("postReset", 1'b0, 32'h0123_4567, 32'h1111_1111, 1'b1, 5'd17, mk(32'h1234_5679, 0, 0, 0, 5'd17));

    $display("[TB] randomised traffic");
    runTraffic("random", 300, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
